// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for the in-order pipeline.
// Tracks in-flight destinations in a shadow pipeline of DEPTH post-ID slots.

module pipe_hazard_opnd #(
   parameter int DEPTH = 3,
   parameter int FW    = 2
) (
   input  logic             id_use,
   input  logic [DEPTH-1:0] id_hit,
   input  logic [DEPTH-1:0] stall_rdy,
   input  logic             ex_use,
   input  logic [DEPTH-1:0] ex_hit,
   input  logic [DEPTH-1:0] fwd_rdy,
   output logic             stall,
   output logic [FW-1:0]    fwd
);
   // Descending scans so the youngest (smallest k) hit has the last word.
   always_comb begin
      stall = 1'b0;
      for (int k = DEPTH-1; k >= 0; k--)
         if (id_hit[k]) stall = !stall_rdy[k];
      stall = stall & id_use;
   end

   always_comb begin
      fwd = '0;
      for (int k = DEPTH-1; k >= 1; k--)
         if (ex_use && ex_hit[k] && fwd_rdy[k]) fwd = FW'(k);
   end
endmodule

module pipe_hazard_ctrl #(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int REG_AW   = 5,
   parameter int FW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_reg_w,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_mem_r,
   input  logic              br_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [31:0]       stall_cnt
);
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_w;
      logic              load;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              use_rs;
      logic              use_rt;
   } slot_t;

   slot_t [DEPTH-1:0]          slot;
   slot_t                      id_slot;
   logic [1:0][REG_AW-1:0]     id_src, ex_src;
   logic [1:0]                 id_use, ex_use;
   logic [1:0][DEPTH-1:0]      id_hit, ex_hit;
   logic [DEPTH-1:0]           wr_live, stall_rdy, fwd_rdy;
   logic [1:0]                 op_stall;
   logic [1:0][FW-1:0]         op_fwd;
   logic                       stall, stall_eff;
   logic                       unused_slot;

   assign id_src = {id_rt, id_rs};
   assign id_use = {id_valid & id_use_rt, id_valid & id_use_rs};
   assign ex_src = {slot[0].rt, slot[0].rs};
   assign ex_use = {slot[0].valid & slot[0].use_rt, slot[0].valid & slot[0].use_rs};

   // A load in slot k can feed a stalled ID reader once it reaches slot LOAD_LAT,
   // and the EX operand once it reaches slot 1+LOAD_LAT.
   genvar k, i;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_slot
         assign wr_live[k]   = slot[k].valid & slot[k].reg_w & (slot[k].rd != '0);
         assign stall_rdy[k] = !slot[k].load || (k >= LOAD_LAT);
         assign fwd_rdy[k]   = !slot[k].load || (k >= LOAD_LAT + 1);
         for (i = 0; i < 2; i++) begin : g_src
            assign id_hit[i][k] = wr_live[k] && (slot[k].rd == id_src[i]);
            assign ex_hit[i][k] = wr_live[k] && (slot[k].rd == ex_src[i]);
         end
      end
      for (i = 0; i < 2; i++) begin : g_opnd
         pipe_hazard_opnd #(.DEPTH(DEPTH), .FW(FW)) u_opnd (
            .id_use    (id_use[i]),
            .id_hit    (id_hit[i]),
            .stall_rdy (stall_rdy),
            .ex_use    (ex_use[i]),
            .ex_hit    (ex_hit[i]),
            .fwd_rdy   (fwd_rdy),
            .stall     (op_stall[i]),
            .fwd       (op_fwd[i])
         );
      end
   endgenerate

   assign stall        = |op_stall;
   assign stall_eff    = stall & ~br_taken;
   assign pc_write     = ~stall_eff;
   assign if_id_write  = ~stall_eff;
   assign if_id_flush  = br_taken;
   assign id_ex_bubble = stall | br_taken;
   assign fwd_a        = op_fwd[0];
   assign fwd_b        = op_fwd[1];

   always_comb begin
      id_slot        = '0;
      id_slot.valid  = 1'b1;
      id_slot.rd     = id_rd;
      id_slot.reg_w  = id_reg_w;
      id_slot.load   = id_mem_r;
      id_slot.rs     = id_rs;
      id_slot.rt     = id_rt;
      id_slot.use_rs = id_use_rs;
      id_slot.use_rt = id_use_rt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot      <= '0;
         stall_cnt <= '0;
      end else begin
         for (int s = 1; s < DEPTH; s++) slot[s] <= slot[s-1];
         slot[0] <= (id_valid && !stall && !br_taken) ? id_slot : '0;
         if (stall_eff && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   // Source fields of older slots are carried for visibility only.
   assign unused_slot = ^slot;
endmodule
